qft_frame_sequencer: RTL
========================

# qft_frame_sequencer

Frame controller for the combinational 4-point QFT datapath. It collects one 4-element complex state vector from a serial sample stream and holds it stable on the datapath inputs. After a configurable settle latency it captures the 4 complex outputs and streams them out serially under valid/ready backpressure. It sits between the sample source and the downstream consumer and is the only driver of the QFT datapath input ports.

## Interface
Parameters:
- IN_W, 8: signed input sample width, integer format with 1 sign bit.
- OUT_W, 13: signed datapath output width, with 5 fractional bits.
- LAT, 1: extra settle cycles between frame-load completion and output capture; range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the current frame.
- s_valid  in  1  input sample valid.
- s_ready  out  1  sequencer can accept a sample.
- s_re, s_im  in  IN_W each  signed input sample, real and imaginary parts.
- dp_in_re, dp_in_im  out  4*IN_W each  registered frame to the datapath; element k occupies bits [IN_W*k +: IN_W].
- dp_out_re, dp_out_im  in  4*OUT_W each  datapath results; element k occupies bits [OUT_W*k +: OUT_W].
- m_valid  out  1  output result valid.
- m_ready  in  1  consumer accepts the result.
- m_re, m_im  out  OUT_W each  signed result.
- m_idx  out  2  index of the result currently presented.
- m_last  out  1  high with element 3.
- busy  out  1  high in WAIT and DRAIN.

## Operation
The block has 3 states: LOAD, WAIT and DRAIN.

- **LOAD**
  - s_ready=1.
  - Each s_valid&&s_ready writes the sample into dp_in slot ld_idx, then ld_idx increments.
  - The accept with ld_idx==3 clears ld_idx, clears wcnt and moves to WAIT.
- **WAIT**
  - s_ready=0, m_valid=0.
  - wcnt increments each cycle.
  - When wcnt==LAT, dp_out_re/dp_out_im are copied into the 4-entry output buffer on that edge, and the state moves to DRAIN with dr_idx=0.
- **DRAIN**
  - m_valid=1. m_re, m_im, m_idx and m_last come from the buffer entry dr_idx and are registered, with no combinational path from inputs.
  - Each m_valid&&m_ready advances dr_idx.
  - The handshake with dr_idx==3 returns to LOAD.

Rules that apply across states:
- dp_in registers change only on LOAD accepts. They keep the last frame through WAIT, DRAIN and flush.
- The output buffer is written only at capture.
- Frames never overlap: s_ready stays 0 until the last result handshake completes.
- flush has priority over every handshake in the same cycle. On flush:
  - the state goes to LOAD and ld_idx, dr_idx and wcnt are cleared;
  - a coincident s or m handshake is discarded, so that sample or result is lost.
- The block does no arithmetic on datapath results except under the macro described in Configuration.

## Timing
- Reset values:
  - state=LOAD, s_ready=1;
  - m_valid=0, m_re=0, m_im=0, m_idx=0, m_last=0;
  - busy=0;
  - dp_in_re=0, dp_in_im=0;
  - all counters 0.
- Reset mid-frame discards all progress immediately and asynchronously.
- Capture occurs on the (LAT+1)-th rising edge after the edge of the 4th accept. The datapath inputs are therefore stable for at least LAT+1 full cycles before capture.
- The first m_valid is high in the cycle after capture.
- Minimum frame period is 4 + (LAT+1) + 4 = 9+LAT cycles with continuous s_valid and m_ready.
- With m_ready held low, m_valid stays 1 and m_re, m_im and m_idx stay stable indefinitely.
- ld_idx and dr_idx are 2-bit counters and never wrap silently; the state change occurs exactly at index 3.
- flush asserted in LOAD with ld_idx==0 has no visible effect.

## Configuration
- **QFT_SEQ_NORM_EN defined:** at capture, each buffered result is the datapath value arithmetically shifted right by 1. This applies the 1/sqrt(4) unitary normalization, with truncation toward negative infinity.
- **QFT_SEQ_NORM_EN undefined:** datapath values are captured verbatim.
- The macro does not change latency or interface.

## Test plan
- **Basic frame:** reset, then stream re=1,1,1,1, im=0 with m_ready=1 and LAT=1.
  - The datapath sees dp_in_re=0x01010101.
  - Result element 0 has m_re=128 (4.0); elements 1–3 have m_re=0; every m_im=0.
  - m_last is high on idx 3.
  - The first m_valid appears 3 cycles after the 4th accept edge.
- **Impulse:** stream re=8,0,0,0 → all 4 results have m_re=256 (8.0) and m_im=0.
  - With QFT_SEQ_NORM_EN defined: all m_re=128.
  - A value of -3 (raw) maps to -2.
- **Backpressure:** hold m_ready=0 for 10 cycles in DRAIN.
  - m_valid stays 1, m_idx stays 0 and values are stable.
  - s_ready stays 0 throughout.
  - Releasing m_ready drains idx 0–3 over 4 cycles; s_ready=1 in the cycle after idx 3 is accepted.
- **Flush during LOAD:** flush after 2 accepts → s_ready stays 1.
  - The next 4 samples form a complete frame with slots 0–3 rewritten in order.
  - Flush coinciding with an m handshake at idx 1 returns to LOAD; no further m_valid appears.
- **Reset mid-DRAIN:** assert rst_n=0 asynchronously at idx 2 → m_valid=0, m_re=0 and s_ready=1 immediately.
  - After release, a new frame runs normally.
- **LAT=0 build:** capture occurs on the edge after the 4th accept, and the first m_valid appears 2 cycles after that accept edge.

Source files
------------

// File: rtl/qft_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : qft_frame_sequencer_if
// Description : Sample stream, datapath and result stream signals of the
//               QFT frame sequencer. The sequencer connects to the slave
//               modport and its environment connects to the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface qft_frame_sequencer_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 13
);
  // Sample stream into the sequencer
  logic                    s_valid;
  logic                    s_ready;
  logic signed [IN_W-1:0]  s_re;
  logic signed [IN_W-1:0]  s_im;

  // Combinational QFT datapath around the sequencer
  logic [4*IN_W-1:0]       dp_in_re;
  logic [4*IN_W-1:0]       dp_in_im;
  logic [4*OUT_W-1:0]      dp_out_re;
  logic [4*OUT_W-1:0]      dp_out_im;

  // Result stream out of the sequencer
  logic                    m_valid;
  logic                    m_ready;
  logic signed [OUT_W-1:0] m_re;
  logic signed [OUT_W-1:0] m_im;
  logic [1:0]              m_idx;
  logic                    m_last;

  modport slave (
    input  s_valid, s_re, s_im, dp_out_re, dp_out_im, m_ready,
    output s_ready, dp_in_re, dp_in_im, m_valid, m_re, m_im, m_idx, m_last
  );

  modport master (
    output s_valid, s_re, s_im, dp_out_re, dp_out_im, m_ready,
    input  s_ready, dp_in_re, dp_in_im, m_valid, m_re, m_im, m_idx, m_last
  );
endinterface
`default_nettype wire

// File: rtl/qft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : qft_frame_sequencer
// Description : Frame controller for the combinational 4-point QFT datapath.
//               Loads 4 complex samples into the datapath input registers,
//               waits LAT+1 settle cycles, captures the 4 results and streams
//               them out under valid/ready backpressure.
//               Optional macro QFT_SEQ_NORM_EN: captured results are
//               arithmetically shifted right by 1 (1/sqrt(4) normalization).
// Revision    : 1.0 - initial release
// ============================================================================
module qft_frame_sequencer #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 13,
  parameter int LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  output logic                        busy,
  qft_frame_sequencer_if.slave        sq_if
);

  localparam logic [3:0] c_LAT = LAT[3:0];

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ld_idx_q, ld_idx_d;
  logic [1:0] dr_idx_q, dr_idx_d;
  logic [3:0] wcnt_q, wcnt_d;

  logic [4*IN_W-1:0]       dp_in_re_q, dp_in_im_q;
  logic signed [OUT_W-1:0] buf_re_q [4];
  logic signed [OUT_W-1:0] buf_im_q [4];
  logic signed [OUT_W-1:0] cap_re   [4];
  logic signed [OUT_W-1:0] cap_im   [4];

  logic s_fire, capture;

  // flush outranks every handshake, so a coincident sample or capture is lost
  assign s_fire  = (state_q == ST_LOAD) && sq_if.s_valid && !flush;
  assign capture = (state_q == ST_WAIT) && (wcnt_q == c_LAT) && !flush;

  // Values written into the output buffer at capture time
  generate
    for (genvar k = 0; k < 4; k++) begin : g_cap
`ifdef QFT_SEQ_NORM_EN
      assign cap_re[k] = $signed(sq_if.dp_out_re[OUT_W*k +: OUT_W]) >>> 1;
      assign cap_im[k] = $signed(sq_if.dp_out_im[OUT_W*k +: OUT_W]) >>> 1;
`else
      assign cap_re[k] = $signed(sq_if.dp_out_re[OUT_W*k +: OUT_W]);
      assign cap_im[k] = $signed(sq_if.dp_out_im[OUT_W*k +: OUT_W]);
`endif
    end
  endgenerate

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      ld_idx_q <= 2'd0;
      dr_idx_q <= 2'd0;
      wcnt_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      ld_idx_q <= ld_idx_d;
      dr_idx_q <= dr_idx_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // Next-state logic; the state changes exactly at index 3, never by wrap
  always_comb begin
    state_d  = state_q;
    ld_idx_d = ld_idx_q;
    dr_idx_d = dr_idx_q;
    wcnt_d   = wcnt_q;
    if (flush) begin
      state_d  = ST_LOAD;
      ld_idx_d = 2'd0;
      dr_idx_d = 2'd0;
      wcnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (sq_if.s_valid) begin
            if (ld_idx_q == 2'd3) begin
              ld_idx_d = 2'd0;
              wcnt_d   = 4'd0;
              state_d  = ST_WAIT;
            end else begin
              ld_idx_d = ld_idx_q + 2'd1;
            end
          end
        end
        ST_WAIT: begin
          if (wcnt_q == c_LAT) begin
            dr_idx_d = 2'd0;
            state_d  = ST_DRAIN;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
        ST_DRAIN: begin
          if (sq_if.m_ready) begin
            if (dr_idx_q == 2'd3) begin
              dr_idx_d = 2'd0;
              state_d  = ST_LOAD;
            end else begin
              dr_idx_d = dr_idx_q + 2'd1;
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // Datapath input frame: written only by accepted samples, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_in_re_q <= '0;
      dp_in_im_q <= '0;
    end else if (s_fire) begin
      for (int k = 0; k < 4; k++) begin
        if (ld_idx_q == 2'(k)) begin
          dp_in_re_q[IN_W*k +: IN_W] <= sq_if.s_re;
          dp_in_im_q[IN_W*k +: IN_W] <= sq_if.s_im;
        end
      end
    end
  end

  // Output buffer: loaded once per frame when the datapath has settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        buf_re_q[k] <= '0;
        buf_im_q[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < 4; k++) begin
        buf_re_q[k] <= cap_re[k];
        buf_im_q[k] <= cap_im[k];
      end
    end
  end

  // Outputs decode registered state only; no input-to-output paths
  assign sq_if.s_ready  = (state_q == ST_LOAD);
  assign sq_if.m_valid  = (state_q == ST_DRAIN);
  assign sq_if.m_re     = buf_re_q[dr_idx_q];
  assign sq_if.m_im     = buf_im_q[dr_idx_q];
  assign sq_if.m_idx    = dr_idx_q;
  assign sq_if.m_last   = (state_q == ST_DRAIN) && (dr_idx_q == 2'd3);
  assign sq_if.dp_in_re = dp_in_re_q;
  assign sq_if.dp_in_im = dp_in_im_q;
  assign busy           = (state_q != ST_LOAD);

endmodule
`default_nettype wire
